// File: rtl/gpio_bank_irq.sv
// Memory-mapped GPIO bank with input synchronisers, atomic set/clear and edge interrupts.
// Optional input debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module gpio_bank_irq #(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0080,
    parameter int          GPIO_WIDTH      = 16,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                  mem_clk,
    input  logic                  cpu_reset,
    input  logic                  mem_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_valid_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [GPIO_WIDTH-1:0] pin_gpio_i,
    output logic [GPIO_WIDTH-1:0] pin_gpio_o,
    output logic [GPIO_WIDTH-1:0] pin_gpio_oe_o,
    output logic                  irq_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST   = BASE + ADDR_WIDTH'(32'h27);
    localparam logic [31:0]           ID_VAL = {8'h47, 16'h0, 8'(GPIO_WIDTH)};

    typedef logic [GPIO_WIDTH-1:0] gpio_t;

    gpio_t en_q, en_d, dir_q, dir_d, idr_q, idr_d, odr_q, odr_d;
    gpio_t rise_en_q, rise_en_d, fall_en_q, fall_en_d, stat_q, stat_d;
    gpio_t prev_q, filt, sync_out, in_mode, rise, fall, stat_set, stat_w1c, wdata;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] rdata_q, rd_mux;
    logic [ADDR_WIDTH-1:0] off;
    logic [3:0]            widx;
    logic                  hit, rd_hit, wr_hit;
    logic                  unused_ok;

    assign off       = mem_addr_i - BASE;
    assign widx      = off[5:2];
    assign hit       = (mem_addr_i >= BASE) && (mem_addr_i <= LAST);
    assign rd_hit    = mem_valid_i && mem_read_i && hit;
    assign wr_hit    = mem_valid_i && mem_write_i && hit;
    assign wdata     = mem_data_i[GPIO_WIDTH-1:0];
    assign unused_ok = ^{off, mem_data_i};

    gpio_t sync_q [SYNC_STAGES];

    always_ff @(posedge mem_clk) begin
        if (cpu_reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pin_gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q [GPIO_WIDTH];
    gpio_t         filt_q;

    // A pin's filtered value follows sync only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge mem_clk) begin
        if (cpu_reset) begin
            filt_q <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (sync_out[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i] <= sync_out[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_out;
`endif

    assign in_mode  = en_q & ~dir_q;
    assign rise     = filt & ~prev_q & in_mode;
    assign fall     = ~filt & prev_q & in_mode;
    assign stat_set = (rise & rise_en_q) | (fall & fall_en_q);

    always_comb begin
        rd_mux = '0;
        case (widx)
            4'h0:    rd_mux[GPIO_WIDTH-1:0] = en_q;
            4'h1:    rd_mux[GPIO_WIDTH-1:0] = dir_q;
            4'h2:    rd_mux[GPIO_WIDTH-1:0] = idr_q;
            4'h3:    rd_mux[GPIO_WIDTH-1:0] = odr_q;
            4'h6:    rd_mux[GPIO_WIDTH-1:0] = rise_en_q;
            4'h7:    rd_mux[GPIO_WIDTH-1:0] = fall_en_q;
            4'h8:    rd_mux[GPIO_WIDTH-1:0] = stat_q;
            4'h9:    rd_mux = DATA_WIDTH'(ID_VAL);
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        dir_d     = dir_q;
        odr_d     = odr_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_w1c  = '0;
        idr_d     = (filt & in_mode) | (idr_q & ~in_mode);
        if (wr_hit) begin
            case (widx)
                4'h0:    en_d      = wdata;
                4'h1:    dir_d     = wdata;
                4'h3:    odr_d     = wdata;
                4'h4:    odr_d     = odr_q | wdata;
                4'h5:    odr_d     = odr_q & ~wdata;
                4'h6:    rise_en_d = wdata;
                4'h7:    fall_en_d = wdata;
                4'h8:    stat_w1c  = wdata;
                default: en_d      = en_q;
            endcase
        end
        // New events override a simultaneous clear of the same bit.
        stat_d = (stat_q & ~stat_w1c) | stat_set;
    end

    always_ff @(posedge mem_clk) begin
        if (cpu_reset) begin
            en_q      <= '0;
            dir_q     <= '0;
            idr_q     <= '0;
            odr_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            prev_q    <= '0;
            valid_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            en_q      <= en_d;
            dir_q     <= dir_d;
            idr_q     <= idr_d;
            odr_q     <= odr_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            prev_q    <= filt;
            valid_q   <= mem_valid_i && hit;
            if (rd_hit) rdata_q <= rd_mux;
        end
    end

    assign mem_valid_o   = valid_q;
    assign mem_data_o    = rdata_q;
    assign pin_gpio_oe_o = en_q & dir_q;
    assign pin_gpio_o    = odr_q & en_q & dir_q;
    assign irq_o         = |(stat_q & (rise_en_q | fall_en_q));

endmodule

// File: tb/tb_gpio_bank_irq.sv
// Randomised self-checking bench for gpio_bank_irq against a cycle-level behavioural model.
module tb_gpio_bank_irq;

    localparam int          GW   = 16;
    localparam int          SS   = 2;
    localparam int          DC   = 4;
    localparam logic [31:0] BASE = 32'h8000_0080;

    logic        mem_clk = 1'b0;
    logic        cpu_reset;
    logic        mem_valid_i, mem_read_i, mem_write_i;
    logic [31:0] mem_addr_i, mem_data_i;
    logic        mem_valid_o;
    logic [31:0] mem_data_o;
    logic [GW-1:0] pin_gpio_i, pin_gpio_o, pin_gpio_oe_o;
    logic        irq_o;

    always #5 mem_clk = ~mem_clk;

    gpio_bank_irq #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
        .GPIO_WIDTH(GW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .mem_clk(mem_clk), .cpu_reset(cpu_reset),
        .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_valid_o(mem_valid_o), .mem_data_o(mem_data_o),
        .pin_gpio_i(pin_gpio_i), .pin_gpio_o(pin_gpio_o), .pin_gpio_oe_o(pin_gpio_oe_o),
        .irq_o(irq_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference state: register file contents, pad history and bus response.
    logic [GW-1:0] m_en, m_dir, m_idr, m_odr, m_re, m_fe, m_stat, m_prev, m_filt;
    logic [GW-1:0] hist[$];
    int            m_run [GW];
    logic          m_valid;
    logic [31:0]   m_rdata;

    function automatic logic [GW-1:0] cur_filt();
`ifdef GPIO_DEBOUNCE_EN
        return m_filt;
`else
        return hist[0];
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        case (off[5:2])
            4'h0: return {16'h0, m_en};
            4'h1: return {16'h0, m_dir};
            4'h2: return {16'h0, m_idr};
            4'h3: return {16'h0, m_odr};
            4'h6: return {16'h0, m_re};
            4'h7: return {16'h0, m_fe};
            4'h8: return {16'h0, m_stat};
            4'h9: return 32'h4700_0010;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = '0; m_dir = '0; m_idr = '0; m_odr = '0; m_re = '0; m_fe = '0;
        m_stat = '0; m_prev = '0; m_filt = '0; m_valid = 1'b0; m_rdata = '0;
        hist.delete();
        for (int s = 0; s < SS; s++) hist.push_back('0);
        for (int i = 0; i < GW; i++) m_run[i] = 0;
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare outputs.
    task automatic tick();
        logic [GW-1:0] f, inm, ev, w1c, wd;
        logic [31:0]   off;
        logic          hit;
        @(posedge mem_clk);
        if (cpu_reset) begin
            model_reset();
        end else begin
            f   = cur_filt();
            inm = m_en & ~m_dir;
            ev  = ((f & ~m_prev & m_re) | (~f & m_prev & m_fe)) & inm;
            hit = (mem_addr_i >= BASE) && (mem_addr_i <= BASE + 32'h27);
            off = mem_addr_i - BASE;
            wd  = mem_data_i[GW-1:0];
            w1c = '0;
            if (mem_valid_i && mem_read_i && hit) m_rdata = model_read(mem_addr_i);
            m_valid = mem_valid_i && hit;
            m_idr   = (f & inm) | (m_idr & ~inm);
            m_prev  = f;
            if (mem_valid_i && mem_write_i && hit) begin
                case (off[5:2])
                    4'h0: m_en  = wd;
                    4'h1: m_dir = wd;
                    4'h3: m_odr = wd;
                    4'h4: m_odr = m_odr | wd;
                    4'h5: m_odr = m_odr & ~wd;
                    4'h6: m_re  = wd;
                    4'h7: m_fe  = wd;
                    4'h8: w1c   = wd;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~w1c) | ev;
`ifdef GPIO_DEBOUNCE_EN
            for (int i = 0; i < GW; i++) begin
                if (hist[0][i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_filt[i] = hist[0][i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`endif
            hist.push_back(pin_gpio_i);
            void'(hist.pop_front());
        end
        #1;
        check("valid", {31'h0, mem_valid_o}, {31'h0, m_valid});
        check("rdata", mem_data_o, m_rdata);
        check("oe", {16'h0, pin_gpio_oe_o}, {16'h0, m_en & m_dir});
        check("pin_o", {16'h0, pin_gpio_o}, {16'h0, m_odr & m_en & m_dir});
        check("irq", {31'h0, irq_o}, {31'h0, |(m_stat & (m_re | m_fe))});
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        mem_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        mem_addr_i  = a;    mem_data_i = d;
        tick();
        mem_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    endtask

    initial begin
        int          op, idx;
        logic [31:0] a, d;
        cpu_reset = 1'b1;
        mem_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        mem_addr_i = '0; mem_data_i = '0; pin_gpio_i = '0;
        model_reset();
        tick(); tick();
        cpu_reset = 1'b0;
        tick();
        check("rst_irq", {31'h0, irq_o}, 32'h0);

        // Output pads and ODR readback latency.
        bus(0, 1, BASE + 32'h00, 32'h0003);
        bus(0, 1, BASE + 32'h04, 32'h0001);
        bus(0, 1, BASE + 32'h0C, 32'h0001);
        check("oe_dir", {16'h0, pin_gpio_oe_o}, 32'h0001);
        check("pin_drv", {16'h0, pin_gpio_o}, 32'h0001);
        bus(1, 0, BASE + 32'h0C, 32'h0);
        check("odr_valid", {31'h0, mem_valid_o}, 32'h1);
        check("odr_rd", mem_data_o, 32'h0000_0001);
        tick();
        check("valid_drop", {31'h0, mem_valid_o}, 32'h0);

        // Atomic set/clear; write-only offsets read zero.
        bus(0, 1, BASE + 32'h10, 32'h00F0);
        bus(0, 1, BASE + 32'h14, 32'h0030);
        bus(1, 0, BASE + 32'h0C, 32'h0);
        check("odr_setclr", mem_data_o, 32'h0000_00C1);
        bus(1, 0, BASE + 32'h10, 32'h0);
        check("oset_rd0", mem_data_o, 32'h0);
        bus(1, 0, BASE + 32'h14, 32'h0);
        check("oclr_rd0", mem_data_o, 32'h0);

        // Rising-edge interrupt on pin 1 and W1C.
        bus(0, 1, BASE + 32'h00, 32'h0002);
        bus(0, 1, BASE + 32'h04, 32'h0000);
        bus(0, 1, BASE + 32'h18, 32'h0002);
        pin_gpio_i[1] = 1'b1;
        tick(); tick(); tick();
        bus(1, 0, BASE + 32'h08, 32'h0);
        check("idr_pin1", mem_data_o, 32'h0000_0002);
        bus(1, 0, BASE + 32'h20, 32'h0);
        check("stat_rise", mem_data_o, 32'h0000_0002);
        check("irq_rise", {31'h0, irq_o}, 32'h1);
        bus(0, 1, BASE + 32'h20, 32'h0002);
        check("irq_w1c", {31'h0, irq_o}, 32'h0);

        // Edge in the same cycle as a W1C of that bit: the set wins.
        pin_gpio_i[1] = 1'b0;
        tick(); tick(); tick(); tick();
        pin_gpio_i[1] = 1'b1;
        tick(); tick();
        bus(0, 1, BASE + 32'h20, 32'h0002);
        bus(1, 0, BASE + 32'h20, 32'h0);
        check("stat_setwins", mem_data_o, 32'h0000_0002);

        // Randomised traffic with pad activity.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) pin_gpio_i[$urandom_range(0, GW-1)] ^= 1'b1;
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 10);
            a   = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            d   = $urandom;
            if (op <= 3)      bus(0, 1, a, d);
            else if (op <= 6) bus(1, 0, a, d);
            else if (op == 7) bus(1, 1, a, d);
            else if (op == 8) bus(1, 1, BASE - 32'd4, d);
            else              tick();
        end

        // Reset in the middle of an ID read.
        cpu_reset = 1'b1;
        bus(1, 0, BASE + 32'h24, 32'h0);
        check("rst_novalid", {31'h0, mem_valid_o}, 32'h0);
        cpu_reset = 1'b0;
        tick();
        check("rst_novalid2", {31'h0, mem_valid_o}, 32'h0);
        check("rst_irq2", {31'h0, irq_o}, 32'h0);
        for (int r = 0; r < 9; r++) begin
            bus(1, 0, BASE + 32'(r * 4), 32'h0);
            check("rst_reg", mem_data_o, 32'h0);
        end
        bus(1, 0, BASE + 32'h28, 32'h0);
        check("oow_valid", {31'h0, mem_valid_o}, 32'h0);
        bus(1, 0, BASE + 32'h24, 32'h0);
        check("id_valid", {31'h0, mem_valid_o}, 32'h1);
        check("id_rd", mem_data_o, 32'h4700_0010);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
